addsub_arbiter: RTL and testbench

Shares a single add/subtract datapath between two requesters. Each requester presents an operation (add or subtract) and two operands. The block grants one requester at a time by round-robin, sequences the operation through a three-state FSM, and returns a registered result tagged with the requester ID. It sits between requester front-ends and the shared 4-bit add/sub unit, replacing direct `in0`-selected add/sub triggering with an arbitrated, handshaked controller.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_unit.sv | 29 ++
 rtl/addsub_arbiter.sv | 125 ++++++++++++
 tb/tb_addsub_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the arbitrated add/sub controller
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/addsub_unit.sv
// rtl/addsub_unit.sv - combinational unsigned add/subtract with carry/borrow out
module addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] data,
    output logic             cout
);

    logic [WIDTH:0] full;

    // The extra top bit is carry for add and borrow (a < b) for subtract.
    always_comb begin
        full = '0;
        if (op == OP_ADD) begin
            full = {1'b0, a} + {1'b0, b};
        end else begin
            full = {1'b0, a} - {1'b0, b};
        end
    end

    assign data = full[WIDTH-1:0];
    assign cout = full[WIDTH];

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin arbiter sharing one add/sub unit between two requesters
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic             res_op,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout
);

    state_t           state;
    state_t           next_state;
    logic             last_id;
    logic             grant0;
    logic             grant1;
    logic             op_q;
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] unit_data;
    logic             unit_cout;

    // Requester 0 wins contention unless it was the most recent winner.
    always_comb begin
        next_state = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || last_id);
                grant1 = req1_valid && !grant0;
                if (grant0 || grant1) begin
                    next_state = EXEC;
                end
            end
            EXEC: next_state = DONE;
            DONE: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (rst) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    addsub_unit #(.WIDTH(WIDTH)) u_unit (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .data (unit_data),
        .cout (unit_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_id   <= 1'b1;
            op_q      <= 1'b0;
            id_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_op    <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        id_q    <= grant1;
                        last_id <= grant1;
                        op_q    <= grant1 ? req1_op : req0_op;
                        a_q     <= grant1 ? req1_a  : req0_a;
                        b_q     <= grant1 ? req1_b  : req0_b;
                    end
                end
                EXEC: begin
                    res_valid <= 1'b1;
                    res_id    <= id_q;
                    res_op    <= op_q;
                    res_data  <= unit_data;
                    res_cout  <= unit_cout;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed self-checking bench for addsub_arbiter
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_op, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_op, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic       res_valid, res_ready, res_id, res_op, res_cout;
    logic [3:0] res_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_op     (res_op),
        .res_data   (res_data),
        .res_cout   (res_cout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-requester operation from IDLE through the result handshake.
    task automatic run_op(input logic id, input logic op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] exp_d, input logic exp_c);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        chk("op_ready", id ? req1_ready : req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("op_valid", res_valid, 1);
        chk("op_id", res_id, id);
        chk("op_data", res_data, exp_d);
        chk("op_cout", res_cout, exp_c);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        res_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", res_valid, 0);
        chk("rst_id", res_id, 0);
        chk("rst_op", res_op, 0);
        chk("rst_data", res_data, 0);
        chk("rst_cout", res_cout, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        rst = 1'b0;
        tick();

        // First operation with latency check
        req0_valid = 1; req0_op = 1; req0_a = 4'h3; req0_b = 4'h4;
        #1;
        chk("first_ready0", req0_ready, 1);
        chk("first_ready1", req1_ready, 0);
        tick();
        req0_valid = 0;
        chk("first_exec_valid", res_valid, 0);
        chk("first_exec_ready0", req0_ready, 0);
        tick();
        chk("first_valid", res_valid, 1);
        chk("first_id", res_id, 0);
        chk("first_op", res_op, 1);
        chk("first_data", res_data, 4'h7);
        chk("first_cout", res_cout, 0);
        tick();
        chk("first_drop", res_valid, 0);

        // Contention after reset: alternating grants, one result per 3 cycles
        rst = 1; tick(); rst = 0;
        req0_valid = 1; req0_op = 1; req0_a = 4'h1; req0_b = 4'h2;
        req1_valid = 1; req1_op = 0; req1_a = 4'h7; req1_b = 4'h3;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_ready1", req1_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            chk("rr_exec_valid", res_valid, 0);
            tick();
            chk("rr_valid", res_valid, 1);
            chk("rr_id", res_id, (i % 2 == 0) ? 0 : 1);
            chk("rr_data", res_data, (i % 2 == 0) ? 4'h3 : 4'h4);
            tick();
        end
        req0_valid = 0;
        req1_valid = 0;

        // Wrap-around and borrow cases
        run_op(0, 1, 4'hF, 4'h2, 4'h1, 1);
        run_op(1, 0, 4'h2, 4'h5, 4'hD, 1);
        run_op(0, 0, 4'h9, 4'h9, 4'h0, 0);

        // Backpressure: result held while req1 waits
        req0_valid = 1; req0_op = 1; req0_a = 4'h5; req0_b = 4'h6;
        res_ready = 0;
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_op = 0; req1_a = 4'h8; req1_b = 4'h1;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 4'hB);
            chk("bp_id", res_id, 0);
            chk("bp_ready1", req1_ready, 0);
            tick();
        end
        res_ready = 1;
        tick();
        chk("bp_release_valid", res_valid, 0);
        chk("bp_release_ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        tick();
        chk("bp_next_id", res_id, 1);
        chk("bp_next_data", res_data, 4'h7);
        tick();

        // Reset during EXEC discards the operation and restores priority
        req0_valid = 1; req0_op = 1; req0_a = 4'h1; req0_b = 4'h1;
        tick();
        req0_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("rx_valid", res_valid, 0);
        chk("rx_data", res_data, 0);
        chk("rx_id", res_id, 0);
        chk("rx_op", res_op, 0);
        chk("rx_cout", res_cout, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rx_no_result", res_valid, 0);
        end
        req0_valid = 1; req0_op = 1; req0_a = 4'h2; req0_b = 4'h3;
        req1_valid = 1; req1_op = 1; req1_a = 4'h1; req1_b = 4'h1;
        #1;
        chk("rx_ready0", req0_ready, 1);
        chk("rx_ready1", req1_ready, 0);
        tick();
        req0_valid = 0;
        req1_valid = 0;
        tick();
        chk("rx_after_data", res_data, 4'h5);
        tick();

        // Operands latched at grant, later changes ignored
        req0_valid = 1; req0_op = 0; req0_a = 4'h9; req0_b = 4'h4;
        tick();
        req0_valid = 0; req0_a = 4'h0; req0_b = 4'hF;
        tick();
        chk("latch_data", res_data, 4'h5);
        chk("latch_cout", res_cout, 0);
        chk("latch_op", res_op, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
